// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled Rx, one-byte holding register with ready/ack handshake.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       overrun,
  output logic       parity_err
`else
  output logic       overrun
`endif
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             rx_meta, rx_s, rx_prev;
  logic             load, drop, ferr;
`ifdef UART_RX_PARITY_EN
  logic             par, par_d, perr;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
`ifdef UART_RX_PARITY_EN
      par   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    load    = 1'b0;
    drop    = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par;
    perr    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end else begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par}) perr = 1'b1;
            else
`endif
            // An ack in the same cycle frees the register, so the new byte loads
            if (!rx_ready || rd_ack) load = 1'b1;
            else                     drop = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= load;
      frame_err <= ferr;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr;
`endif
      if (load) begin
        rx_data  <= shift;
        rx_ready <= 1'b1;
      end else if (rd_ack) begin
        rx_ready <= 1'b0;
      end
      if (drop)                    overrun <= 1'b1;
      else if (rd_ack && rx_ready) overrun <= 1'b0;
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a byte-level model.
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       reset, Rx, rd_ack;
  logic [7:0] rx_data;
  logic       rx_ready, rx_valid, rx_busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 CLK = ~CLK;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .Rx(Rx), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .overrun(overrun), .parity_err(parity_err)
`else
    .overrun(overrun)
`endif
  );

  int checks = 0, errors = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int e_valid = 0, e_ferr = 0, e_perr = 0;
  logic [7:0] m_data = '0;
  bit m_ready = 0, m_ovr = 0;

  always @(negedge CLK) begin
    if (rx_valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (CPB) @(negedge CLK);
  endtask

  // Line-level frame plus the expected effect on the holding register.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_ok);
    if (!stop_ok) e_ferr++;
`ifdef UART_RX_PARITY_EN
    else if (par_flip) e_perr++;
`endif
    else if (!m_ready) begin
      m_data  = b;
      m_ready = 1;
      e_valid++;
    end else m_ovr = 1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
    if (m_ready) begin
      m_ready = 0;
      m_ovr   = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/data"},    32'(rx_data),   32'(m_data));
    check({tag, "/ready"},   32'(rx_ready),  32'(m_ready));
    check({tag, "/overrun"}, 32'(overrun),   32'(m_ovr));
    check({tag, "/valids"},  32'(valid_cnt), 32'(e_valid));
    check({tag, "/ferrs"},   32'(ferr_cnt),  32'(e_ferr));
    check({tag, "/perrs"},   32'(perr_cnt),  32'(e_perr));
    check({tag, "/busy"},    32'(rx_busy),   32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bit stop_ok;
    int gap;

    reset = 1'b0; Rx = 1'b1; rd_ack = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check("reset_idle", {19'd0, rx_data, rx_ready, rx_valid, rx_busy, frame_err, overrun}, '0);
    end

    send_frame(8'hB2, 1, 0); idle(4); check_state("b2");
    ack(); idle(2); check_state("b2_ack");

    Rx = 1'b0; idle(4); Rx = 1'b1; idle(40);
    check_state("glitch");

    send_frame(8'h55, 0, 0);
    idle(40);
    Rx = 1'b1; idle(20);
    check_state("frame_err");
    send_frame(8'h3C, 1, 0); idle(4); check_state("after_break");
    ack(); idle(2);

    send_frame(8'hA1, 1, 0);
    send_frame(8'h7E, 1, 0);
    idle(4); check_state("overrun");
    ack(); idle(2); check_state("overrun_ack");
    ack(); idle(2); check_state("ack_ignored");

    // Leave a byte held so the reset has something to clear
    send_frame(8'h81, 1, 0); idle(4);
    Rx = 1'b0; idle(CPB);
    Rx = 1'b1; idle(3 * CPB);
    check("mid_frame_busy", 32'(rx_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset", {19'd0, rx_data, rx_ready, rx_valid, rx_busy, frame_err, overrun}, '0);
    m_data = '0; m_ready = 0; m_ovr = 0;
    idle(3);
    reset = 1'b1;
    idle(20); check_state("post_reset");
    send_frame(8'h0F, 1, 0); idle(4); check_state("0f");
    ack(); idle(2);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1, 1); idle(4); check_state("parity_bad");
`endif

    for (int n = 0; n < 10; n++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      gap     = $urandom_range(0, 20);
      send_frame(b, stop_ok, 0);
      Rx = 1'b1;
      idle(4 + gap);
      check_state("random");
      if ($urandom_range(0, 1) == 1) begin
        ack(); idle(2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
